// File: rtl/clk_div_ctrl.sv
// Programmable clock divider controller: glitch-free start/stop and divide-ratio
// updates that are only applied at a period boundary (the O_CLK 1->0 edge).
module clk_div_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_EN,
    input  logic             I_DIV_VALID,
    input  logic [CNT_W-1:0] I_DIV,
    output logic             O_DIV_READY,
    output logic             O_CLK,
    output logic             O_TICK,
    output logic             O_ERR,
    output logic [CNT_W-1:0] O_DIV_ACT,
    output logic [1:0]       O_STATE
);

    // Ratio handshake: a transfer happens on a rising I_CLK edge where
    // I_DIV_VALID && O_DIV_READY; the source holds I_DIV stable until then.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        STOPPING = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_act, div_act_n;
    logic [CNT_W-1:0] pend_div, pend_div_n;
    logic             pend_valid, pend_valid_n;
    logic             clk_q, clk_n;
    logic             tick_q, tick_n;
    logic             err_q, err_n;
    logic             xfer, div_zero, toggle, boundary;

    always_comb begin
        xfer     = I_DIV_VALID && !pend_valid;
        div_zero = (I_DIV == '0);
        toggle   = (state != IDLE) && (cnt == div_act - ONE);
        boundary = toggle && clk_q;

        state_n      = state;
        cnt_n        = cnt;
        clk_n        = clk_q;
        div_act_n    = div_act;
        pend_div_n   = pend_div;
        pend_valid_n = pend_valid;
        tick_n       = 1'b0;
        err_n        = xfer && div_zero;

        if (state != IDLE) begin
            if (toggle) begin
                clk_n = !clk_q;
                cnt_n = '0;
            end else begin
                cnt_n = cnt + ONE;
            end
            tick_n = boundary;
            // The boundary consumes the slot as it was before this edge, so a
            // transfer landing on the same edge waits for the next boundary.
            if (boundary && pend_valid) begin
                div_act_n    = pend_div;
                pend_valid_n = 1'b0;
            end
            if (xfer && !div_zero) begin
                pend_div_n   = I_DIV;
                pend_valid_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (xfer && !div_zero) div_act_n = I_DIV;
                if (I_EN) state_n = RUN;
            end
            RUN: begin
                if (!I_EN) begin
                    if (!clk_q || boundary) state_n = IDLE;
                    else                    state_n = STOPPING;
                end
            end
            STOPPING: begin
                if (I_EN)          state_n = RUN;
                else if (boundary) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Leaving the run states parks the output low and flushes any ratio
        // still waiting so it is never stranded while idle.
        if (state != IDLE && state_n == IDLE) begin
            clk_n = 1'b0;
            cnt_n = '0;
            if (pend_valid_n) begin
                div_act_n    = pend_div_n;
                pend_valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state      <= IDLE;
            cnt        <= '0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            div_act    <= DEF_DIV;
            pend_div   <= '0;
            pend_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            clk_q      <= clk_n;
            tick_q     <= tick_n;
            err_q      <= err_n;
            div_act    <= div_act_n;
            pend_div   <= pend_div_n;
            pend_valid <= pend_valid_n;
        end
    end

    assign O_DIV_READY = !pend_valid;
    assign O_CLK       = clk_q;
    assign O_TICK      = tick_q;
    assign O_ERR       = err_q;
    assign O_DIV_ACT   = div_act;
    assign O_STATE     = state;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl: a phase-countdown reference model predicts
// every cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_clk_div_ctrl;

    localparam int CNT_W       = 16;
    localparam int DEFAULT_DIV = 10;
    localparam int VW          = CNT_W + 6;

    logic             I_CLK = 1'b0;
    logic             I_RST;
    logic             I_EN;
    logic             I_DIV_VALID;
    logic [CNT_W-1:0] I_DIV;
    logic             O_DIV_READY;
    logic             O_CLK;
    logic             O_TICK;
    logic             O_ERR;
    logic [CNT_W-1:0] O_DIV_ACT;
    logic [1:0]       O_STATE;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST), .I_EN(I_EN), .I_DIV_VALID(I_DIV_VALID),
        .I_DIV(I_DIV), .O_DIV_READY(O_DIV_READY), .O_CLK(O_CLK), .O_TICK(O_TICK),
        .O_ERR(O_ERR), .O_DIV_ACT(O_DIV_ACT), .O_STATE(O_STATE)
    );

    always #5 I_CLK = ~I_CLK;

    logic [VW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: state 0/1/2 = idle/run/stopping, m_left = edges until
    // the next O_CLK toggle, pending ratio kept as a queue of at most one entry.
    int m_st, m_left, m_div;
    bit m_clk, m_tick, m_err;
    int m_pend[$];

    bit offer;
    int offer_div;

    function automatic logic [VW-1:0] pack();
        logic [CNT_W-1:0] d;
        logic [1:0]       s;
        d = CNT_W'(m_div);
        s = 2'(m_st);
        return {m_clk, m_tick, m_err, (m_pend.size() == 0), d, s};
    endfunction

    function automatic void model_reset();
        m_st = 0; m_left = 0; m_div = DEFAULT_DIV;
        m_clk = 0; m_tick = 0; m_err = 0;
        m_pend.delete();
    endfunction

    // Advance one counting edge; returns 1 when this edge is a 1->0 boundary.
    function automatic bit m_count();
        m_left = m_left - 1;
        if (m_left != 0) return 1'b0;
        m_clk = !m_clk;
        if (!m_clk) begin
            m_tick = 1;
            if (m_pend.size() != 0) m_div = m_pend.pop_front();
        end
        m_left = m_div;
        return !m_clk;
    endfunction

    task automatic model_step(input bit en, input bit valid, input int div, output bit xfer);
        bit b;
        bit to_idle;
        xfer    = valid && (m_pend.size() == 0);
        m_tick  = 0;
        m_err   = xfer && (div == 0);
        to_idle = 0;
        if (m_st == 0) begin
            if (xfer && div != 0) m_div = div;
            if (en) begin
                m_st = 1; m_clk = 0; m_left = m_div;
            end
        end else begin
            if (m_st == 1 && !en && !m_clk) begin
                to_idle = 1;
            end else begin
                b = m_count();
                if (m_st == 1) begin
                    if (!en) begin
                        if (b) to_idle = 1;
                        else   m_st = 2;
                    end
                end else begin
                    if (en)     m_st = 1;
                    else if (b) to_idle = 1;
                end
            end
            if (xfer && div != 0) m_pend.push_back(div);
            if (to_idle) begin
                m_st = 0; m_clk = 0;
                if (m_pend.size() != 0) m_div = m_pend.pop_front();
            end
        end
    endtask

    function automatic int pick();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return 1;
        return $urandom_range(1, 12);
    endfunction

    always @(negedge I_CLK) begin
        logic [VW-1:0] e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {O_CLK, O_TICK, O_ERR, O_DIV_READY, O_DIV_ACT, O_STATE};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle_outputs t=%0t got clk/tick/err/rdy/div/st=%b/%b/%b/%b/%0d/%b expected %b/%b/%b/%b/%0d/%b",
                         $time, a[VW-1], a[VW-2], a[VW-3], a[VW-4], a[CNT_W+1:2], a[1:0],
                         e[VW-1], e[VW-2], e[VW-3], e[VW-4], e[CNT_W+1:2], e[1:0]);
            end
        end
    end

    task automatic cycle(input bit en_req, input int offer_pct);
        bit x;
        @(negedge I_CLK);
        I_EN = en_req;
        if (!offer && $urandom_range(0, 99) < offer_pct) begin
            offer     = 1;
            offer_div = pick();
        end
        I_DIV_VALID = offer;
        I_DIV       = offer ? CNT_W'(offer_div) : CNT_W'($urandom_range(0, 65535));
        @(posedge I_CLK);
        model_step(I_EN, I_DIV_VALID, int'(I_DIV), x);
        if (x) offer = 0;
        exp_q.push_back(pack());
    endtask

    task automatic set_offer(input int v);
        offer     = 1;
        offer_div = v;
    endtask

    task automatic check_reset_now(input string name);
        logic [VW-1:0] a, e;
        a = {O_CLK, O_TICK, O_ERR, O_DIV_READY, O_DIV_ACT, O_STATE};
        e = {1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(DEFAULT_DIV), 2'b00};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, a, e);
        end
    endtask

    // Reset asserted between clock edges while the divided clock is high.
    task automatic async_reset_mid_high();
        int guard;
        guard = 0;
        while (!(m_clk && m_st != 0) && guard < 300) begin
            cycle(1, 30);
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL reset_wait no high phase within %0d cycles, required one", guard);
        end
        @(negedge I_CLK);
        #1;
        I_RST = 1; I_EN = 0; I_DIV_VALID = 0; offer = 0;
        #1;
        check_reset_now("async_reset");
        model_reset();
        @(posedge I_CLK);
        exp_q.push_back(pack());
        #2 I_RST = 0;
    endtask

    initial begin
        int hold;
        bit en_lvl;
        I_RST = 1; I_EN = 0; I_DIV_VALID = 0; I_DIV = '0; offer = 0; offer_div = 0;
        model_reset();
        #1 check_reset_now("reset_state");
        repeat (2) begin
            @(posedge I_CLK);
            exp_q.push_back(pack());
        end
        #2 I_RST = 0;

        repeat (45) cycle(1, 0);          // default ratio from reset
        repeat (12) cycle(0, 0);
        set_offer(3);
        repeat (2) cycle(0, 0);
        repeat (20) cycle(1, 0);          // ratio 3
        repeat (6) cycle(0, 0);
        set_offer(1);
        cycle(1, 0);                      // transfer and start on the same edge
        repeat (10) cycle(1, 0);
        set_offer(10);
        repeat (25) cycle(1, 0);          // applied at a boundary
        set_offer(4);
        repeat (40) cycle(1, 0);
        set_offer(0);
        repeat (20) cycle(1, 0);          // rejected ratio
        async_reset_mid_high();

        en_lvl = 1;
        for (int i = 0; i < 1600; i++) begin
            if (hold == 0) begin
                en_lvl = !en_lvl;
                hold   = $urandom_range(1, 40);
            end
            hold--;
            cycle(en_lvl, 20);
            if (i == 600 || i == 1200) async_reset_mid_high();
        end

        @(negedge I_CLK);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain left %0d entries, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
